// File: rtl/prbs15_checker.sv
// prbs15_checker: self-synchronising PRBS-15 (x^15 + x^14 + 1) byte-stream checker.
// Hunts for sequence alignment, verifies LOCK_BYTES error-free bytes, then counts
// bit errors against a locally regenerated sequence until UNLOCK_BYTES
// consecutive errored bytes drop lock.
// Ports:
//   clk         - rising-edge clock
//   rst         - asynchronous active-high reset
//   data_in     - received byte, bit 7 is the earliest bit on the line
//   data_valid  - data_in valid this cycle
//   err_clr     - synchronous clear of bit_err_cnt / byte_cnt
//   locked      - checker is locked to the stream
//   byte_err    - one-cycle pulse, last locked byte had at least one bit error
//   bit_err_cnt - saturating count of bit errors seen while locked
//   byte_cnt    - saturating count of bytes checked while locked
module prbs15_checker #(
  parameter int unsigned LOCK_BYTES   = 4,
  parameter int unsigned UNLOCK_BYTES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             byte_err,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam int unsigned GOOD_W = $clog2(LOCK_BYTES + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_BYTES + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [14:0]       s, s_nxt;
  logic              load_cnt, load_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [BAD_W-1:0]  bad_cnt, bad_nxt;
  logic              locked_nxt, byte_err_nxt;
  logic [CNT_W-1:0]  bit_nxt, byte_nxt;

  logic [14:0]       s_adv;
  logic [7:0]        pred;
  logic [7:0]        err;
  logic [3:0]        pc;
  logic [CNT_W-1:0]  bit_base, byte_base;
  logic [SUM_W-1:0]  bit_sum, byte_sum;

  // Predicted next byte and the sequence state advanced past it.
  always_comb begin
    logic nb;
    s_adv = s;
    pred  = '0;
    nb    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      nb    = s_adv[13] ^ s_adv[14];
      pred  = {pred[6:0], nb};
      s_adv = {s_adv[13:0], nb};
    end
  end

  // Error vector and its population count.
  always_comb begin
    err = data_in ^ pred;
    pc  = '0;
    for (int i = 0; i < 8; i++) begin
      pc = pc + 4'(err[i]);
    end
  end

  // Saturating counter sums; a clear in the same cycle restarts from zero.
  always_comb begin
    bit_base  = err_clr ? '0 : bit_err_cnt;
    byte_base = err_clr ? '0 : byte_cnt;
    bit_sum   = {1'b0, bit_base} + SUM_W'(pc);
    byte_sum  = {1'b0, byte_base} + SUM_W'(1);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      s           <= '0;
      load_cnt    <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      locked      <= 1'b0;
      byte_err    <= 1'b0;
      bit_err_cnt <= '0;
      byte_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      s           <= s_nxt;
      load_cnt    <= load_nxt;
      good_cnt    <= good_nxt;
      bad_cnt     <= bad_nxt;
      locked      <= locked_nxt;
      byte_err    <= byte_err_nxt;
      bit_err_cnt <= bit_nxt;
      byte_cnt    <= byte_nxt;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_nxt    = state;
    s_nxt        = s;
    load_nxt     = load_cnt;
    good_nxt     = good_cnt;
    bad_nxt      = bad_cnt;
    byte_err_nxt = 1'b0;
    bit_nxt      = bit_base;
    byte_nxt     = byte_base;

    if (data_valid) begin
      unique case (state)
        HUNT: begin
          // Received bits fill s; two bytes cover all 15 bits.
          s_nxt = {s[6:0], data_in};
          if (load_cnt) begin
            state_nxt = VERIFY;
            load_nxt  = 1'b0;
            good_nxt  = '0;
          end else begin
            load_nxt = 1'b1;
          end
        end
        VERIFY: begin
          // s == 0 is the LFSR lockup state and must never be accepted.
          if (err == 8'h00 && s != 15'h0000) begin
            s_nxt    = s_adv;
            good_nxt = good_cnt + GOOD_W'(1);
            if (good_cnt == GOOD_W'(LOCK_BYTES - 1)) begin
              state_nxt = LOCKED;
              bad_nxt   = '0;
            end
          end else begin
            state_nxt = HUNT;
            load_nxt  = 1'b1;
            s_nxt     = {s[6:0], data_in};
          end
        end
        LOCKED: begin
          // Advance on predicted bits so line errors never corrupt s.
          s_nxt    = s_adv;
          bit_nxt  = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
          byte_nxt = byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
          if (err != 8'h00) begin
            byte_err_nxt = 1'b1;
            if (bad_cnt == BAD_W'(UNLOCK_BYTES - 1)) begin
              state_nxt = HUNT;
              load_nxt  = 1'b0;
              bad_nxt   = '0;
            end else begin
              bad_nxt = bad_cnt + BAD_W'(1);
            end
          end else begin
            bad_nxt = '0;
          end
        end
        default: begin
          state_nxt = HUNT;
        end
      endcase
    end

    locked_nxt = (state_nxt == LOCKED);
  end

endmodule
